queue_unpacker: RTL and testbench

Word-to-byte serializer that does the reverse of the 4-stage byte queue. It captures a 32-bit word on a rising edge of LOAD. It then emits the word one byte at a time, oldest byte first (DATAIN[31:24] first, DATAIN[7:0] last), over a valid/ready handshake. It sits between a word-wide producer and a byte-wide consumer, and reports progress through BUSY, REMAIN, DONE and OVERRUN.

---
 rtl/queue_unpacker.sv | 128 ++++++++++++
 tb/tb_queue_unpacker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/queue_unpacker.sv
// -----------------------------------------------------------------------------
// queue_unpacker
//
// Word-to-byte serializer. A rising edge on LOAD captures DATAIN. The captured
// word is then emitted one byte at a time, most significant byte first, over a
// valid/ready handshake. Progress is reported through BUSY, REMAIN, DONE and
// OVERRUN.
//
// Handshake: a byte transfers at a rising CLK edge where DOUT_VALID and
// DOUT_READY are both 1. DOUT_VALID, once raised, stays high and DATAOUT stays
// stable until that byte transfers. DOUT_VALID and DATAOUT come straight from
// flops, so there is no combinational path from DOUT_READY to either of them.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous, active-high reset
//   LOAD         in   load request; only its rising edge matters
//   DATAIN       in   8*NBYTES-bit word, sampled on an accepted LOAD edge
//   DOUT_READY   in   consumer can take the current byte
//   DATAOUT      out  current byte (0x00 when idle)
//   DOUT_VALID   out  DATAOUT holds a byte to transfer
//   BUSY         out  a word is being serialized (same as DOUT_VALID)
//   REMAIN       out  bytes of the current word not yet transferred
//   DONE         out  one-cycle pulse after the last byte transfers
//   OVERRUN      out  one-cycle pulse when a LOAD edge arrives while busy
//   dbg_state_o  out  FSM state (0 = IDLE, 1 = SEND)
// -----------------------------------------------------------------------------
module queue_unpacker #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES,
  localparam int RW     = $clog2(NBYTES + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD,
  input  logic [W-1:0]  DATAIN,
  input  logic          DOUT_READY,
  output logic [7:0]    DATAOUT,
  output logic          DOUT_VALID,
  output logic          BUSY,
  output logic [RW-1:0] REMAIN,
  output logic          DONE,
  output logic          OVERRUN,
  output logic          dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            load_prev_q;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            load_edge;
  logic            xfer;

  // A LOAD that is already high when RST releases counts as an edge on the
  // first clock, because load_prev_q comes out of reset at 0.
  assign load_edge = LOAD && !load_prev_q;
  assign xfer      = (state_q == SEND) && DOUT_READY;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_edge) begin
          sreg_d  = DATAIN;
          cnt_d   = RW'(NBYTES);
          state_d = SEND;
        end
      end
      SEND: begin
        // The word in flight is never replaced; a new edge is only flagged.
        // This also covers an edge coinciding with the final transfer.
        if (load_edge) begin
          ovr_d = 1'b1;
        end
        if (xfer) begin
          // Zero fill means the top byte reads 0x00 once the word is drained.
          sreg_d = sreg_q << 8;
          cnt_d  = cnt_q - RW'(1);
          if (cnt_q == RW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      load_prev_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_prev_q <= LOAD;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign DATAOUT     = sreg_q[W-1 -: 8];
  assign DOUT_VALID  = (state_q == SEND);
  assign BUSY        = (state_q == SEND);
  assign REMAIN      = cnt_q;
  assign DONE        = done_q;
  assign OVERRUN     = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_queue_unpacker.sv
// -----------------------------------------------------------------------------
// tb_queue_unpacker
//
// Directed bench for queue_unpacker (NBYTES = 4). A table of per-cycle vectors
// {LOAD, DATAIN, DOUT_READY, expected outputs after the edge} covers the basic
// word, backpressure, overrun, an edge on the final transfer and LOAD held
// high. Hand-written sequences cover asynchronous reset, LOAD high at reset
// release and reset in the middle of a word. A negedge monitor pops every
// transferred byte against an expected byte queue.
// -----------------------------------------------------------------------------
module tb_queue_unpacker;

  logic        CLK;
  logic        RST;
  logic        LOAD;
  logic [31:0] DATAIN;
  logic        DOUT_READY;
  logic [7:0]  DATAOUT;
  logic        DOUT_VALID;
  logic        BUSY;
  logic [2:0]  REMAIN;
  logic        DONE;
  logic        OVERRUN;
  logic        dbg_state;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    logic        load;
    logic [31:0] din;
    logic        rdy;
    logic [7:0]  e_dout;
    logic        e_valid;
    logic [2:0]  e_remain;
    logic        e_done;
    logic        e_ovr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  queue_unpacker dut (
    .CLK         (CLK),
    .RST         (RST),
    .LOAD        (LOAD),
    .DATAIN      (DATAIN),
    .DOUT_READY  (DOUT_READY),
    .DATAOUT     (DATAOUT),
    .DOUT_VALID  (DOUT_VALID),
    .BUSY        (BUSY),
    .REMAIN      (REMAIN),
    .DONE        (DONE),
    .OVERRUN     (OVERRUN),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- helpers ----------------
  task automatic add(input logic l, input logic [31:0] d, input logic r,
                     input logic [7:0] ed, input logic ev, input logic [2:0] er,
                     input logic edn, input logic eo);
    vec_t v;
    v.load = l; v.din = d; v.rdy = r;
    v.e_dout = ed; v.e_valid = ev; v.e_remain = er; v.e_done = edn; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input string sig, input logic [31:0] got,
                     input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s %s got=%0h exp=%0h", nm, sig, got, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic [7:0] ed, input logic ev,
                            input logic [2:0] er, input logic edn, input logic eo);
    cmp(nm, "DATAOUT",    {24'd0, DATAOUT}, {24'd0, ed});
    cmp(nm, "DOUT_VALID", {31'd0, DOUT_VALID}, {31'd0, ev});
    cmp(nm, "BUSY",       {31'd0, BUSY}, {31'd0, ev});
    cmp(nm, "REMAIN",     {29'd0, REMAIN}, {29'd0, er});
    cmp(nm, "DONE",       {31'd0, DONE}, {31'd0, edn});
    cmp(nm, "OVERRUN",    {31'd0, OVERRUN}, {31'd0, eo});
  endtask

  // Drive inputs shortly after an edge, then check one time unit after the next.
  task automatic step(input logic l, input logic [31:0] d, input logic r);
    LOAD = l; DATAIN = d; DOUT_READY = r;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // A transfer happens at the next rising edge whenever valid and ready are
  // both high at the falling edge (inputs only change just after rising edges).
  always @(negedge CLK) begin
    if (!RST && DOUT_VALID && DOUT_READY) begin
      nchecks++;
      if (exp_q.size() == 0) begin
        nerrors++;
        $display("FAIL xfer_unexpected got=%0h exp=none", DATAOUT);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (DATAOUT !== e) begin
          nerrors++;
          $display("FAIL xfer_byte got=%0h exp=%0h", DATAOUT, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bp[4];
    bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44;

    // Basic word
    add(1, 32'hA1B2C3D4, 1, 8'hA1, 1, 3'd4, 0, 0);
    add(0, 32'h0,        1, 8'hB2, 1, 3'd3, 0, 0);
    add(0, 32'h0,        1, 8'hC3, 1, 3'd2, 0, 0);
    add(0, 32'h0,        1, 8'hD4, 1, 3'd1, 0, 0);
    add(0, 32'h0,        1, 8'h00, 0, 3'd0, 1, 0);
    add(0, 32'h0,        1, 8'h00, 0, 3'd0, 0, 0);
    // Backpressure: three stalled cycles around every transfer; DATAIN noise
    add(1, 32'h11223344, 0, 8'h11, 1, 3'd4, 0, 0);
    add(0, $urandom,     0, 8'h11, 1, 3'd4, 0, 0);
    add(0, $urandom,     0, 8'h11, 1, 3'd4, 0, 0);
    for (int i = 1; i < 4; i++) begin
      add(0, $urandom, 1, bp[i], 1, 3'(4 - i), 0, 0);
      for (int s = 0; s < 3; s++) add(0, $urandom, 0, bp[i], 1, 3'(4 - i), 0, 0);
    end
    add(0, $urandom, 1, 8'h00, 0, 3'd0, 1, 0);
    add(0, $urandom, 0, 8'h00, 0, 3'd0, 0, 0);
    // Overrun after two transfers; LOAD then held high (no second edge)
    add(1, 32'hDEADBEEF, 1, 8'hDE, 1, 3'd4, 0, 0);
    add(0, 32'h0,        1, 8'hAD, 1, 3'd3, 0, 0);
    add(0, 32'h0,        1, 8'hBE, 1, 3'd2, 0, 0);
    add(1, 32'h01020304, 0, 8'hBE, 1, 3'd2, 0, 1);
    add(1, 32'h01020304, 1, 8'hEF, 1, 3'd1, 0, 0);
    add(0, 32'h01020304, 1, 8'h00, 0, 3'd0, 1, 0);
    add(0, 32'h0,        1, 8'h00, 0, 3'd0, 0, 0);
    // LOAD edge on the same cycle as the final transfer is dropped
    add(1, 32'h0F1E2D3C, 1, 8'h0F, 1, 3'd4, 0, 0);
    add(0, 32'h0,        1, 8'h1E, 1, 3'd3, 0, 0);
    add(0, 32'h0,        1, 8'h2D, 1, 3'd2, 0, 0);
    add(0, 32'h0,        1, 8'h3C, 1, 3'd1, 0, 0);
    add(1, 32'h99999999, 1, 8'h00, 0, 3'd0, 1, 1);
    add(1, 32'h99999999, 1, 8'h00, 0, 3'd0, 0, 0);
    add(0, 32'h0,        1, 8'h00, 0, 3'd0, 0, 0);
    // LOAD held high for 10 cycles: one word only, no overrun
    add(1, 32'h55AA55AA, 1, 8'h55, 1, 3'd4, 0, 0);
    add(1, 32'h55AA55AA, 1, 8'hAA, 1, 3'd3, 0, 0);
    add(1, 32'h55AA55AA, 1, 8'h55, 1, 3'd2, 0, 0);
    add(1, 32'h55AA55AA, 1, 8'hAA, 1, 3'd1, 0, 0);
    add(1, 32'h55AA55AA, 1, 8'h00, 0, 3'd0, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 32'h55AA55AA, 1, 8'h00, 0, 3'd0, 0, 0);
    add(0, 32'h0, 1, 8'h00, 0, 3'd0, 0, 0);

    // Expected transferred bytes, in order, including the sequences below
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4,
              8'h11, 8'h22, 8'h33, 8'h44,
              8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h0F, 8'h1E, 8'h2D, 8'h3C,
              8'h55, 8'hAA, 8'h55, 8'hAA,
              8'hCA, 8'hFE,
              8'h0B, 8'hAD, 8'hC0, 8'hDE};

    // ---- Reset: asynchronous clear before any clock edge ----
    RST = 1'b0;
    LOAD = 1'($urandom_range(0, 1));
    DATAIN = $urandom;
    DOUT_READY = 1'($urandom_range(0, 1));
    #1 RST = 1'b1;
    #1 check_outs("reset_async", 8'h00, 0, 3'd0, 0, 0);
    LOAD = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check_outs("reset_held", 8'h00, 0, 3'd0, 0, 0);
    RST = 1'b0;
    step(0, $urandom, 1);
    check_outs("reset_release", 8'h00, 0, 3'd0, 0, 0);

    // ---- Table ----
    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].din, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_valid,
                 vecs[i].e_remain, vecs[i].e_done, vecs[i].e_ovr);
    end

    // ---- Reset mid-word after two transfers ----
    step(1, 32'hCAFEF00D, 1);
    check_outs("mid_load", 8'hCA, 1, 3'd4, 0, 0);
    step(0, 32'h0, 1);
    check_outs("mid_x1", 8'hFE, 1, 3'd3, 0, 0);
    step(0, 32'h0, 1);
    check_outs("mid_x2", 8'hF0, 1, 3'd2, 0, 0);
    #2 RST = 1'b1;
    #1 check_outs("mid_rst_async", 8'h00, 0, 3'd0, 0, 0);
    // LOAD high and new data while reset releases: capture on the first edge
    LOAD = 1'b1; DATAIN = 32'h0BADC0DE;
    @(posedge CLK); #1;
    check_outs("mid_rst_held", 8'h00, 0, 3'd0, 0, 0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    check_outs("rel_load", 8'h0B, 1, 3'd4, 0, 0);
    step(1, 32'h0BADC0DE, 1);
    check_outs("rel_x1", 8'hAD, 1, 3'd3, 0, 0);
    step(0, 32'h0, 1);
    check_outs("rel_x2", 8'hC0, 1, 3'd2, 0, 0);
    step(0, 32'h0, 1);
    check_outs("rel_x3", 8'hDE, 1, 3'd1, 0, 0);
    step(0, 32'h0, 1);
    check_outs("rel_done", 8'h00, 0, 3'd0, 1, 0);
    step(0, 32'h0, 0);
    check_outs("rel_idle", 8'h00, 0, 3'd0, 0, 0);

    // Every expected byte must have been transferred
    @(negedge CLK);
    cmp("scoreboard", "left_in_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
